// File: rtl/fp_align_pkg.sv
// rtl/fp_align_pkg.sv - shared widths and state encoding for the mantissa alignment stage
// Contents: EXP_W_DEF / MAN_W_DEF default widths, GRS_W guard/round/sticky width,
//           state_t FSM encoding {IDLE, SHIFT, DONE}.
package fp_align_pkg;

    localparam int EXP_W_DEF = 4;
    localparam int MAN_W_DEF = 8;
    localparam int GRS_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/align_shift_step.sv
// rtl/align_shift_step.sv - one-bit right shift that folds the two lowest bits into sticky
// Ports: din  [W-1:0]  value {mantissa, G, R, S}
//        dout [W-1:0]  {0, din[W-1:2], din[1] | din[0]}
module align_shift_step #(
    parameter int W = 11
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    // The bit leaving the R position merges into S so no shifted-out one is ever lost.
    assign dout = {1'b0, din[W-1:2], din[1] | din[0]};

endmodule

// File: rtl/mantissa_align.sv
// rtl/mantissa_align.sv - FP adder alignment stage: operand swap and iterative GRS right shift
// Optional feature macro: ALIGN_EARLY_OUT_EN (shift distances >= MAN_W+3 finish in one step).
// Ports: clk, rst_n (async, active-low)
//        in_valid / in_ready      operand handshake (ready only in IDLE)
//        x_man, y_man, x_exp, y_exp, x_lt_y, exp_diff   operands and exponent-difference results
//        out_valid / out_ready    result handshake (valid only in DONE)
//        big_man, small_man, res_exp, swapped           aligned result
module mantissa_align
    import fp_align_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MAN_W-1:0]       x_man,
    input  logic [MAN_W-1:0]       y_man,
    input  logic [EXP_W-1:0]       x_exp,
    input  logic [EXP_W-1:0]       y_exp,
    input  logic                   x_lt_y,
    input  logic [EXP_W-1:0]       exp_diff,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MAN_W-1:0]       big_man,
    output logic [MAN_W+GRS_W-1:0] small_man,
    output logic [EXP_W-1:0]       res_exp,
    output logic                   swapped
);

    localparam int SW = MAN_W + GRS_W;

`ifdef ALIGN_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    state_t            state, state_d;
    logic [EXP_W-1:0]  cnt;
    logic              accept;
    logic              diff_big;
    logic [EXP_W-1:0]  diff_cap;
    logic [MAN_W-1:0]  sel_small;
    logic [SW-1:0]     shifted;

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Beyond SW shifts every bit has already collapsed into sticky, so the count saturates.
    // When diff_big is set, exp_diff >= SW, so SW is representable in EXP_W bits.
    assign diff_big  = (32'(exp_diff) >= 32'(SW));
    assign diff_cap  = diff_big ? EXP_W'(SW) : exp_diff;
    assign sel_small = x_lt_y ? x_man : y_man;

    align_shift_step #(.W(SW)) u_step (
        .din  (small_man),
        .dout (shifted)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (diff_cap == '0 || (EARLY_OUT && diff_big))
                        state_d = DONE;
                    else
                        state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Leave on the edge where cnt goes 1 -> 0.
                if (cnt == EXP_W'(1))
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            big_man   <= '0;
            small_man <= '0;
            res_exp   <= '0;
            swapped   <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (accept) begin
                        big_man <= x_lt_y ? y_man : x_man;
                        res_exp <= x_lt_y ? y_exp : x_exp;
                        swapped <= x_lt_y;
                        if (EARLY_OUT && diff_big) begin
                            small_man <= {{(SW-1){1'b0}}, |sel_small};
                            cnt       <= '0;
                        end else begin
                            small_man <= {sel_small, {GRS_W{1'b0}}};
                            cnt       <= diff_cap;
                        end
                    end
                end
                SHIFT: begin
                    small_man <= shifted;
                    cnt       <= cnt - EXP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mantissa_align.sv
// tb/tb_mantissa_align.sv - directed self-checking bench for mantissa_align
module tb_mantissa_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x_man, y_man;
    logic [3:0]  x_exp, y_exp;
    logic        x_lt_y;
    logic [3:0]  exp_diff;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  big_man;
    logic [10:0] small_man;
    logic [3:0]  res_exp;
    logic        swapped;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mantissa_align dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_man     (x_man),
        .y_man     (y_man),
        .x_exp     (x_exp),
        .y_exp     (y_exp),
        .x_lt_y    (x_lt_y),
        .exp_diff  (exp_diff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .big_man   (big_man),
        .small_man (small_man),
        .res_exp   (res_exp),
        .swapped   (swapped)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents operands for one cycle; returns #1 after the accepting edge.
    task automatic start_op(input logic [7:0] xm, input logic [3:0] xe,
                            input logic [7:0] ym, input logic [3:0] ye,
                            input logic lt, input logic [3:0] d);
        @(negedge clk);
        x_man = xm; x_exp = xe; y_man = ym; y_exp = ye;
        x_lt_y = lt; exp_diff = d; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Edges after the accepting edge until out_valid is seen (0: valid right after accept).
    task automatic run_op(input string tag,
                          input logic [7:0] xm, input logic [3:0] xe,
                          input logic [7:0] ym, input logic [3:0] ye,
                          input logic lt, input logic [3:0] d, input int exp_edges);
        int edges;
        start_op(xm, xe, ym, ye, lt, d);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_lat"}, edges, exp_edges);
    endtask

    task automatic check_res(input string tag, input logic [7:0] b, input logic [10:0] s,
                             input logic [3:0] e, input logic sw);
        check({tag, "_big"},   big_man,   b);
        check({tag, "_small"}, small_man, s);
        check({tag, "_exp"},   res_exp,   e);
        check({tag, "_swap"},  swapped,   sw);
        check({tag, "_inrdy"}, in_ready,  1'b0);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drain_ovld"}, out_valid, 1'b0);
        check({tag, "_drain_irdy"}, in_ready,  1'b1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x_man = '0; y_man = '0; x_exp = '0; y_exp = '0; x_lt_y = 1'b0; exp_diff = '0;
        #1;
        check("rst_irdy",  in_ready,  1'b1);
        check("rst_ovld",  out_valid, 1'b0);
        check("rst_small", small_man, 11'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Case 1: X big, two shifts, no sticky.
        run_op("c1", 8'hB4, 4'd5, 8'h90, 4'd3, 1'b0, 4'd2, 2);
        check_res("c1", 8'hB4, 11'h120, 4'd5, 1'b0);
        drain("c1");

        // Case 2: Y big, four shifts, sticky picks up the low one.
        run_op("c2", 8'h81, 4'd2, 8'hC0, 4'd6, 1'b1, 4'd4, 4);
        check_res("c2", 8'hC0, 11'h041, 4'd6, 1'b1);
        drain("c2");

        // Case 4: distance beyond the cap collapses everything into sticky.
`ifdef ALIGN_EARLY_OUT_EN
        run_op("c4", 8'hFF, 4'd0, 8'h80, 4'd15, 1'b1, 4'd15, 0);
`else
        run_op("c4", 8'hFF, 4'd0, 8'h80, 4'd15, 1'b1, 4'd15, 11);
`endif
        check_res("c4", 8'h80, 11'h001, 4'd15, 1'b1);
        drain("c4");

        // Case 3: equal exponents, tie keeps X big, no shift.
        run_op("c3", 8'hA0, 4'd7, 8'hA0, 4'd7, 1'b0, 4'd0, 0);
        check_res("c3", 8'hA0, 11'h500, 4'd7, 1'b0);

        // Case 5: backpressure in DONE while in_valid toggles with other operands.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            x_man = 8'h11 * 8'(i + 1); y_man = 8'h3C; x_exp = 4'd1; y_exp = 4'd9;
            x_lt_y = 1'b1; exp_diff = 4'd8;
            @(posedge clk);
            #1;
            check("c5_ovld",  out_valid, 1'b1);
            check("c5_irdy",  in_ready,  1'b0);
            check("c5_big",   big_man,   8'hA0);
            check("c5_small", small_man, 11'h500);
            check("c5_exp",   res_exp,   4'd7);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain("c5");

        // Case 6: reset during SHIFT of case 2, then case 1 again.
        start_op(8'h81, 4'd2, 8'hC0, 4'd6, 1'b1, 4'd4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("c6_irdy",  in_ready,  1'b1);
        check("c6_ovld",  out_valid, 1'b0);
        check("c6_big",   big_man,   8'h00);
        check("c6_small", small_man, 11'h000);
        check("c6_exp",   res_exp,   4'd0);
        check("c6_swap",  swapped,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("c6r", 8'hB4, 4'd5, 8'h90, 4'd3, 1'b0, 4'd2, 2);
        check_res("c6r", 8'hB4, 11'h120, 4'd5, 1'b0);
        drain("c6r");

        // Distance one: single shift, sticky from the discarded R bit stays clear.
        run_op("d1", 8'hFF, 4'd4, 8'hFF, 4'd3, 1'b0, 4'd1, 1);
        check_res("d1", 8'hFF, 11'h3FC, 4'd4, 1'b0);
        drain("d1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
